// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encoding,
// sequencer states and the fixed divide-by-zero quotient pattern.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Quotient reported when the divisor is zero
    localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

    // Bit 1 of the op code selects divide, bit 0 selects the unsigned form
    function automatic logic opIsDiv(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic opIsSigned(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Two's-complement negate-if. Used both to take operand magnitudes and to
// restore the sign of products, quotients and remainders.
module cond_negate #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Works on operand magnitudes (radix-2 shift-add multiply, restoring divide)
// for DATA_W cycles, then applies the sign fix-up and writes HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_srcA,
    input  logic [DATA_W-1:0] i_srcB,
    input  logic              i_hi_we,
    input  logic              i_lo_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_div_by_zero
);

    state_t            r_state;
    state_t            w_nextState;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_op;
    logic              r_negRes;
    logic              r_negRem;
    logic              r_divZero;
    logic [DATA_W-1:0] r_magA;
    logic [DATA_W-1:0] r_magB;
    logic [DATA_W-1:0] r_rawA;
    logic [DATA_W-1:0] r_accHi;
    logic [DATA_W-1:0] r_accLo;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic              w_negA;
    logic              w_negB;
    logic [DATA_W-1:0] w_absA;
    logic [DATA_W-1:0] w_absB;
    logic [DATA_W:0]   w_mulPartial;
    logic [DATA_W:0]   w_divTrial;
    logic              w_qBit;
    logic [DATA_W-1:0] w_divRem;
    logic [DATA_W-1:0] w_divLo;
    logic [2*DATA_W-1:0] w_product;
    logic [DATA_W-1:0] w_quotient;
    logic [DATA_W-1:0] w_remainder;
    logic              w_divisorZero;

    // Operand magnitudes are taken only for the signed op forms
    assign w_negA = opIsSigned(i_op) & i_srcA[DATA_W-1];
    assign w_negB = opIsSigned(i_op) & i_srcB[DATA_W-1];

    cond_negate #(.W(DATA_W)) u_absA (
        .i_neg (w_negA),
        .i_val (i_srcA),
        .o_val (w_absA)
    );

    cond_negate #(.W(DATA_W)) u_absB (
        .i_neg (w_negB),
        .i_val (i_srcB),
        .o_val (w_absB)
    );

    // Multiply step: accLo holds the remaining multiplier bits, accHi the
    // running partial product; the carry shifts down into accHi each cycle.
    assign w_mulPartial = r_accLo[0] ? ({1'b0, r_accHi} + {1'b0, r_magA})
                                     : {1'b0, r_accHi};

    // Restoring divide step: accHi is the partial remainder, accLo shifts the
    // dividend out at the top and the quotient bits in at the bottom.
    assign w_divTrial = {r_accHi, r_accLo[DATA_W-1]} - {1'b0, r_magB};
    assign w_qBit     = ~w_divTrial[DATA_W];
    assign w_divRem   = w_qBit ? w_divTrial[DATA_W-1:0]
                               : {r_accHi[DATA_W-2:0], r_accLo[DATA_W-1]};
    assign w_divLo    = {r_accLo[DATA_W-2:0], w_qBit};

    assign w_divisorZero = (r_magB == '0);

    cond_negate #(.W(2*DATA_W)) u_fixProduct (
        .i_neg (r_negRes),
        .i_val ({r_accHi, r_accLo}),
        .o_val (w_product)
    );

    cond_negate #(.W(DATA_W)) u_fixQuotient (
        .i_neg (r_negRes),
        .i_val (r_accLo),
        .o_val (w_quotient)
    );

    cond_negate #(.W(DATA_W)) u_fixRemainder (
        .i_neg (r_negRem),
        .i_val (r_accHi),
        .o_val (w_remainder)
    );

    // Sequencer state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE -> ITER (DATA_W cycles) -> FIX -> DONE -> IDLE
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (i_start) w_nextState = ITER;
            ITER: if (r_count == '0) w_nextState = FIX;
            FIX:  w_nextState = DONE;
            DONE: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Operand capture, iteration datapath, HI/LO writes and divide-by-zero flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count   <= '0;
            r_op      <= OP_MULT;
            r_negRes  <= 1'b0;
            r_negRem  <= 1'b0;
            r_divZero <= 1'b0;
            r_magA    <= '0;
            r_magB    <= '0;
            r_rawA    <= '0;
            r_accHi   <= '0;
            r_accLo   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_hi_we) r_hi <= i_wdata;
                    if (i_lo_we) r_lo <= i_wdata;
                    if (i_start) begin
                        r_op      <= i_op;
                        r_negRes  <= w_negA ^ w_negB;
                        r_negRem  <= w_negA;
                        r_magA    <= w_absA;
                        r_magB    <= w_absB;
                        r_rawA    <= i_srcA;
                        r_accHi   <= '0;
                        r_accLo   <= opIsDiv(i_op) ? w_absA : w_absB;
                        r_count   <= CNT_W'(DATA_W - 1);
                        r_divZero <= 1'b0;
                    end
                end
                ITER: begin
                    if (opIsDiv(r_op)) begin
                        r_accHi <= w_divRem;
                        r_accLo <= w_divLo;
                    end else begin
                        {r_accHi, r_accLo} <= {w_mulPartial, r_accLo[DATA_W-1:1]};
                    end
                    if (r_count != '0) r_count <= r_count - CNT_W'(1);
                end
                FIX: begin
                    if (!opIsDiv(r_op)) begin
                        r_hi <= w_product[2*DATA_W-1:DATA_W];
                        r_lo <= w_product[DATA_W-1:0];
                    end else if (w_divisorZero) begin
                        r_hi      <= r_rawA;
                        r_lo      <= DIVZERO_LO;
                        r_divZero <= 1'b1;
                    end else begin
                        r_hi <= w_remainder;
                        r_lo <= w_quotient;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_hi          = r_hi;
    assign o_lo          = r_lo;
    assign o_busy        = (r_state != IDLE);
    assign o_done        = (r_state == DONE);
    assign o_div_by_zero = r_divZero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, MT writes,
// asynchronous reset mid-operation and a randomized run against an
// arithmetic reference model.
module tb_muldiv_unit;

    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] srcA;
    logic [DATA_W-1:0] srcB;
    logic              hiWe;
    logic              loWe;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] hiOut;
    logic [DATA_W-1:0] loOut;
    logic              busy;
    logic              done;
    logic              divByZero;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] expHi = 32'h0;
    logic [31:0] expLo = 32'h0;
    logic        expDz = 1'b0;

    muldiv_unit #(.DATA_W(DATA_W)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_op          (op),
        .i_srcA        (srcA),
        .i_srcB        (srcB),
        .i_hi_we       (hiWe),
        .i_lo_we       (loWe),
        .i_wdata       (wdata),
        .o_hi          (hiOut),
        .o_lo          (loOut),
        .o_busy        (busy),
        .o_done        (done),
        .o_div_by_zero (divByZero)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts it and reports a failure
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model written from the MIPS arithmetic rules
    task automatic refModel(input logic [1:0] mOp, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] hi,
                            output logic [31:0] lo, output logic dz);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        case (mOp)
            2'b00: begin
                prod = 64'(sa * sb);
                hi = prod[63:32];
                lo = prod[31:0];
            end
            2'b01: begin
                prod = {32'h0, a} * {32'h0, b};
                hi = prod[63:32];
                lo = prod[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                    dz = 1'b1;
                end else if (mOp == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endtask

    // Launch one op in the current cycle (called #1 after an edge, DUT idle)
    // and follow it cycle by cycle through completion into IDLE.
    task automatic applyStimulus(input logic [1:0] sOp, input logic [31:0] a,
                                 input logic [31:0] b, input bit interfere,
                                 input bit mtWith, input logic [31:0] mtData);
        logic [31:0] newHi;
        logic [31:0] newLo;
        logic        newDz;
        refModel(sOp, a, b, newHi, newLo, newDz);
        start = 1'b1;
        op    = sOp;
        srcA  = a;
        srcB  = b;
        if (mtWith) begin
            hiWe  = 1'b1;
            loWe  = 1'b1;
            wdata = mtData;
            expHi = mtData;
            expLo = mtData;
        end
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                start = 1'b0;
                hiWe  = 1'b0;
                loWe  = 1'b0;
                srcA  = $urandom;
                srcB  = $urandom;
                checkOutput("dzClearedAtStart", {63'h0, divByZero}, 64'h0);
            end
            if (interfere && k == 10) begin
                start = 1'b1;
                hiWe  = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end
            if (interfere && k == 11) begin
                start = 1'b0;
                hiWe  = 1'b0;
            end
            checkOutput($sformatf("busy@%0d", k), {63'h0, busy}, {63'h0, (k <= 34)});
            checkOutput($sformatf("done@%0d", k), {63'h0, done}, {63'h0, (k == 34)});
            if (k == 10 || k == 33) begin
                checkOutput($sformatf("hiHold@%0d", k), {32'h0, hiOut}, {32'h0, expHi});
                checkOutput($sformatf("loHold@%0d", k), {32'h0, loOut}, {32'h0, expLo});
            end
            if (k == 34) begin
                checkOutput($sformatf("hi op%0d %h %h", sOp, a, b), {32'h0, hiOut}, {32'h0, newHi});
                checkOutput($sformatf("lo op%0d %h %h", sOp, a, b), {32'h0, loOut}, {32'h0, newLo});
                checkOutput("divByZero", {63'h0, divByZero}, {63'h0, newDz});
            end
        end
        expHi = newHi;
        expLo = newLo;
        expDz = newDz;
    endtask

    // MTHI/MTLO write in an idle cycle, checked one cycle later
    task automatic applyMoveTo(input bit wrHi, input bit wrLo, input logic [31:0] data);
        hiWe  = wrHi;
        loWe  = wrLo;
        wdata = data;
        @(posedge clk);
        #1;
        hiWe = 1'b0;
        loWe = 1'b0;
        if (wrHi) expHi = data;
        if (wrLo) expLo = data;
        checkOutput("mtHi", {32'h0, hiOut}, {32'h0, expHi});
        checkOutput("mtLo", {32'h0, loOut}, {32'h0, expLo});
    endtask

    initial begin
        logic [1:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        srcA  = '0;
        srcB  = '0;
        hiWe  = 1'b0;
        loWe  = 1'b0;
        wdata = '0;

        #12;
        checkOutput("resetHi",   {32'h0, hiOut}, 64'h0);
        checkOutput("resetLo",   {32'h0, loOut}, 64'h0);
        checkOutput("resetBusy", {63'h0, busy}, 64'h0);
        checkOutput("resetDone", {63'h0, done}, 64'h0);
        checkOutput("resetDz",   {63'h0, divByZero}, 64'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed operations");
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        checkOutput("multuMaxHi", {32'h0, expHi}, 64'hFFFF_FFFE);
        applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b11, 32'd5, 32'd0, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b01, 32'd2, 32'd3, 1'b0, 1'b0, 32'h0);
        applyStimulus(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0, 32'h0);

        $display("[TB] ignored start and MTHI while busy");
        applyStimulus(2'b00, 32'd12345, 32'hFFFF_FF85, 1'b1, 1'b0, 32'h0);

        $display("[TB] MTHI/MTLO in idle");
        applyMoveTo(1'b0, 1'b1, 32'h0000_1234);
        applyMoveTo(1'b1, 1'b0, 32'hCAFE_0001);
        applyMoveTo(1'b1, 1'b1, 32'h5555_AAAA);
        applyStimulus(2'b11, 32'd1000, 32'd33, 1'b0, 1'b1, 32'h0BAD_F00D);

        $display("[TB] asynchronous reset mid divide");
        start = 1'b1;
        op    = 2'b10;
        srcA  = 32'h7FFF_0000;
        srcB  = 32'd9;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        #3;
        reset = 1'b1;
        #1;
        checkOutput("asyncRstBusy", {63'h0, busy}, 64'h0);
        checkOutput("asyncRstHi",   {32'h0, hiOut}, 64'h0);
        checkOutput("asyncRstLo",   {32'h0, loOut}, 64'h0);
        checkOutput("asyncRstDone", {63'h0, done}, 64'h0);
        #3;
        reset = 1'b0;
        expHi = 32'h0;
        expLo = 32'h0;
        expDz = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            checkOutput("noDoneAfterRst", {63'h0, done}, 64'h0);
            checkOutput("noBusyAfterRst", {63'h0, busy}, 64'h0);
        end
        checkOutput("hiAfterRst", {32'h0, hiOut}, 64'h0);
        applyStimulus(2'b10, 32'h7FFF_0000, 32'd9, 1'b0, 1'b0, 32'h0);

        $display("[TB] randomized operations");
        for (int n = 0; n < 24; n++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = $urandom;
            rB  = $urandom;
            if ($urandom_range(0, 5) == 0) rB = 32'h0;
            if ($urandom_range(0, 5) == 0) rA = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) rB = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) applyMoveTo(1'($urandom_range(0, 1)), 1'b1, $urandom);
            applyStimulus(rOp, rA, rB, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide sequencer beside the single-cycle ALU in the MIPS execute stage; owns the HI/LO architectural registers.
- Executes MULT, MULTU, DIV and DIVU iteratively. It uses radix-2 shift-add for multiply and restoring division for divide, both on operand magnitudes, followed by a sign fix-up.
- Exposes a start/busy/done handshake so the hazard unit can stall MFHI/MFLO and new mul/div ops while an operation is in flight.

Parameters:
- DATA_W, 32, operand and HI/LO width. Only 32 is verified.
- CNT_W, $clog2(DATA_W), iteration counter width.

Ports:
- i_clk  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  launch an operation; sampled only in IDLE
- i_op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- i_srcA  in  DATA_W  rs operand (multiplicand / dividend)
- i_srcB  in  DATA_W  rt operand (multiplier / divisor)
- i_hi_we  in  1  MTHI write enable
- i_lo_we  in  1  MTLO write enable
- i_wdata  in  DATA_W  MTHI/MTLO data
- o_hi  out  DATA_W  HI register
- o_lo  out  DATA_W  LO register
- o_busy  out  1  operation in flight
- o_done  out  1  one-cycle completion pulse
- o_div_by_zero  out  1  last divide had a zero divisor

Behaviour:
- Reset (asynchronous, any state): state=IDLE, o_hi=0, o_lo=0, o_busy=0, o_done=0, o_div_by_zero=0, counter=0. An operation in flight is discarded with no partial HI/LO update.
- States: IDLE -> ITER -> FIX -> DONE -> IDLE.
- IDLE:
  - If i_start=1 at an edge: latch i_op, the sign of A, the sign of B, |A| and |B|; clear the accumulator; counter=DATA_W-1; go to ITER.
  - Absolute value is applied only for signed ops (MULT, DIV). Unsigned ops take the operands raw.
- ITER:
  - One iteration per cycle for exactly DATA_W cycles.
  - Advance to FIX when the counter reaches 0.
  - i_start is ignored.
- FIX:
  - Apply sign correction and write HI/LO at the exiting edge, then go to DONE.
  - Multiply: the 64-bit product is negated when signA^signB, and only for MULT. Then HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, negated when signA^signB (DIV only). HI=remainder, negated when signA (DIV only).
- DONE: o_done=1 for exactly this one cycle, then go to IDLE. i_start in DONE is ignored.
- Latency: i_start high in cycle 0 gives the following.
  - o_busy=1 in cycles 1..34.
  - o_done=1 in cycle 34.
  - New o_hi/o_lo are visible from cycle 34.
  - The earliest next accepted start is cycle 35.
- o_busy = (state != IDLE), registered state decode, no glitches.
- Division by zero (divisor == 0):
  - Full latency is still taken.
  - Result: LO=all ones, HI=i_srcA as latched (unsigned value, no sign processing).
  - o_div_by_zero is set at the FIX edge. It is cleared at the next accepted start.
- Signed overflow cases (no trap, match MIPS):
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - MULT 0x80000000 * 0x80000000 gives HI=0x40000000, LO=0.
- MTHI/MTLO:
  - Accepted only when state==IDLE; ignored while busy, since the hazard unit stalls them.
  - i_hi_we and i_lo_we may both be high in the same cycle; both registers are written.
  - If a write and i_start occur in the same IDLE cycle, the write takes effect and the operation result later overwrites it.
- o_hi/o_lo hold their value in all states except the FIX edge and accepted MT writes.

Decomposition:
- Package muldiv_pkg holds:
  - op encoding localparams OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enum (IDLE, ITER, FIX, DONE);
  - the DIVZERO_LO constant (all ones).
- One natural sub-module, cond_negate: a DATA_W/2*DATA_W-parameterized two's-complement negate-if. It is reused for operand magnitudes and for the result fix-up.
- The FSM and the iteration datapath stay in muldiv_unit.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> cycle 34: o_done=1, HI=0xFFFFFFFE, LO=0x00000001; o_busy high in cycles 1..34 exactly.
- MULT -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIVU 5/0 -> o_div_by_zero=1, LO=0xFFFFFFFF, HI=5. A following MULTU 2*3 start clears the flag; result HI=0, LO=6.
- i_start and i_hi_we pulsed at cycle 10 of a running op -> both ignored, result unchanged. MTLO 0x1234 in IDLE -> o_lo=0x1234 next cycle.
- i_reset asserted asynchronously at cycle 15 of a DIV, mid-cycle -> immediately o_busy=0, HI=LO=0, no o_done pulse. A new op after release completes normally.
